video_pattern_checker: RTL and testbench

Sink-side companion to the video test pattern source. It recovers pixel coordinates from de/hsync/vsync using the same counting rules as the generator and recomputes the expected RGB value for every active pixel. It compares that value against the received data and measures active width and height. At each frame boundary it reports an error count and a pass/fail verdict. It sits on the far side of a video pipeline (scaler, FIFO, serializer loopback) as a self-check.

---
 rtl/video_pattern_checker.sv | 179 +++++++++++++++++
 tb/tb_video_pattern_checker.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/video_pattern_checker.sv
// Sink-side video test pattern checker: recovers x/y from de/hsync/vsync, compares pixels, reports per frame.
// Optional first-error capture (err_x/err_y/err_data) is enabled by defining VIDEO_CHECK_FIRST_ERR_EN.
module video_pattern_checker (
   input  logic        clk,
   input  logic        rst,
   input  logic        de,
   input  logic        hsync,
   input  logic        vsync,
   input  logic [23:0] data,
   output logic        locked,
   output logic        frame_done,
   output logic        frame_ok,
   output logic [15:0] err_count,
   output logic [15:0] width,
   output logic [15:0] height,
   output logic        width_mismatch
`ifdef VIDEO_CHECK_FIRST_ERR_EN
   ,
   output logic [15:0] err_x,
   output logic [15:0] err_y,
   output logic [23:0] err_data
`endif
);

   typedef enum logic [1:0] {IDLE, SYNC, ACTIVE} state_t;

   state_t      state;
   logic        hsync_r, vsync_r;
   logic        hs_rise, vs_rise, vs_fall;
   logic [15:0] x, y;
   logic [23:0] exp_pix;
   logic        pix_valid, pix_err;

   logic [15:0] err_run, line_cnt, height_run, first_w;
   logic        first_seen, mismatch_run;

   logic [15:0] line_total, err_nxt, height_nxt, first_w_nxt;
   logic        first_seen_nxt, mismatch_nxt, line_end, line_close;

`ifdef VIDEO_CHECK_FIRST_ERR_EN
   logic [15:0] ex_run, ey_run;
   logic [23:0] ed_run;
`endif

   assign hs_rise   = hsync & ~hsync_r;
   assign vs_rise   = vsync & ~vsync_r;
   assign vs_fall   = ~vsync & vsync_r;

   assign exp_pix   = {x[8] ? x[7:0] : 8'h00,
                       y[8] ? y[7:0] : 8'h00,
                       x[9] ? x[7:0] : 8'h00};
   assign pix_valid = de & ~vsync & (state == ACTIVE);
   assign pix_err   = pix_valid & (data != exp_pix);

   // The pixel sharing a cycle with hs_rise still belongs to the line being closed.
   always_comb begin
      // NOTE: every output of this block gets a default first, so no path can infer a latch.
      err_nxt        = err_run;
      height_nxt     = height_run;
      first_w_nxt    = first_w;
      first_seen_nxt = first_seen;
      mismatch_nxt   = mismatch_run;
      line_total     = line_cnt + {15'd0, pix_valid};
      line_end       = hs_rise | vs_rise;
      line_close     = line_end & (line_total != 16'd0);
      if (pix_err && (err_run != 16'hFFFF))
         err_nxt = err_run + 16'd1;
      if (line_close) begin
         height_nxt = height_run + 16'd1;
         if (!first_seen) begin
            first_w_nxt    = line_total;
            first_seen_nxt = 1'b1;
         end else if (line_total != first_w) begin
            mismatch_nxt = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: all state here uses non-blocking assignments so every register samples pre-edge values.
      if (rst) begin
         state          <= IDLE;
         hsync_r        <= 1'b0;
         vsync_r        <= 1'b0;
         x              <= 16'd0;
         y              <= 16'd0;
         err_run        <= 16'd0;
         line_cnt       <= 16'd0;
         height_run     <= 16'd0;
         first_w        <= 16'd0;
         first_seen     <= 1'b0;
         mismatch_run   <= 1'b0;
         locked         <= 1'b0;
         frame_done     <= 1'b0;
         frame_ok       <= 1'b0;
         err_count      <= 16'd0;
         width          <= 16'd0;
         height         <= 16'd0;
         width_mismatch <= 1'b0;
`ifdef VIDEO_CHECK_FIRST_ERR_EN
         ex_run         <= 16'd0;
         ey_run         <= 16'd0;
         ed_run         <= 24'd0;
         err_x          <= 16'd0;
         err_y          <= 16'd0;
         err_data       <= 24'd0;
`endif
      end else begin
         hsync_r    <= hsync;
         vsync_r    <= vsync;
         frame_done <= 1'b0;

         if (vsync) begin
            x <= 16'd0;
            y <= 16'd0;
         end else if (hs_rise) begin
            y <= y + 16'd1;
            x <= 16'd0;
         end else if (de) begin
            x <= x + 16'd1;
         end

         case (state)
            IDLE: begin
               if (vsync)
                  state <= SYNC;
            end
            SYNC: begin
               if (vs_fall) begin
                  locked       <= 1'b1;
                  err_run      <= 16'd0;
                  line_cnt     <= 16'd0;
                  height_run   <= 16'd0;
                  first_w      <= 16'd0;
                  first_seen   <= 1'b0;
                  mismatch_run <= 1'b0;
`ifdef VIDEO_CHECK_FIRST_ERR_EN
                  ex_run       <= 16'd0;
                  ey_run       <= 16'd0;
                  ed_run       <= 24'd0;
`endif
                  state        <= ACTIVE;
               end
            end
            ACTIVE: begin
               err_run      <= err_nxt;
               height_run   <= height_nxt;
               first_w      <= first_w_nxt;
               first_seen   <= first_seen_nxt;
               mismatch_run <= mismatch_nxt;
               line_cnt     <= line_end ? 16'd0 : line_total;
`ifdef VIDEO_CHECK_FIRST_ERR_EN
               if (pix_err && (err_run == 16'd0)) begin
                  ex_run <= x;
                  ey_run <= y;
                  ed_run <= data;
               end
`endif
               if (vs_rise) begin
                  frame_done     <= 1'b1;
                  frame_ok       <= (err_nxt == 16'd0) && !mismatch_nxt;
                  err_count      <= err_nxt;
                  width          <= first_w_nxt;
                  height         <= height_nxt;
                  width_mismatch <= mismatch_nxt;
`ifdef VIDEO_CHECK_FIRST_ERR_EN
                  err_x          <= ex_run;
                  err_y          <= ey_run;
                  err_data       <= ed_run;
`endif
                  state          <= SYNC;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_video_pattern_checker.sv
// Bench for video_pattern_checker: frame-level scoreboard built from the sent stream, checked every cycle.
module tb_video_pattern_checker;

   logic        clk = 1'b0;
   logic        rst, de, hsync, vsync;
   logic [23:0] data;
   logic        locked, frame_done, frame_ok, width_mismatch;
   logic [15:0] err_count, width, height;
`ifdef VIDEO_CHECK_FIRST_ERR_EN
   logic [15:0] err_x, err_y;
   logic [23:0] err_data;
`endif

   video_pattern_checker dut (
      .clk(clk), .rst(rst), .de(de), .hsync(hsync), .vsync(vsync), .data(data),
      .locked(locked), .frame_done(frame_done), .frame_ok(frame_ok),
      .err_count(err_count), .width(width), .height(height),
      .width_mismatch(width_mismatch)
`ifdef VIDEO_CHECK_FIRST_ERR_EN
      , .err_x(err_x), .err_y(err_y), .err_data(err_data)
`endif
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic        ok;
      logic [15:0] err;
      logic [15:0] width;
      logic [15:0] height;
      logic        mism;
      logic [15:0] ex;
      logic [15:0] ey;
      logic [23:0] ed;
   } rep_t;

   int   n_checks = 0;
   int   n_pass   = 0;
   int   cyc      = 0;
   int   done_seen = 0;
   rep_t rep_q[$];
   int   due_q[$];
   rep_t cur;
   rep_t acc;
   bit   have_first;
   bit   model_active;

   // Frame description consumed by send_frame
   int   f_nb, f_lines, f_vs_len, f_err_x, f_err_y, f_rst_line;
   int   f_len[128];
   bit   f_overlap, f_force_ff, f_rand_err;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   function automatic logic [23:0] pattern(input int x, input int y);
      logic [15:0] xv, yv;
      logic [7:0]  r, g, b;
      xv = x[15:0];
      yv = y[15:0];
      r = xv[8] ? xv[7:0] : 8'h00;
      g = yv[8] ? yv[7:0] : 8'h00;
      b = xv[9] ? xv[7:0] : 8'h00;
      return {r, g, b};
   endfunction

   task automatic drive(input logic d, input logic h, input logic v, input logic [23:0] dat);
      de = d; hsync = h; vsync = v; data = dat;
      @(posedge clk);
      #1;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_locked"}, locked, 0);
      check({tag, "_frame_done"}, frame_done, 0);
      check({tag, "_frame_ok"}, frame_ok, 0);
      check({tag, "_err_count"}, err_count, 0);
      check({tag, "_width"}, width, 0);
      check({tag, "_height"}, height, 0);
      check({tag, "_width_mismatch"}, width_mismatch, 0);
`ifdef VIDEO_CHECK_FIRST_ERR_EN
      check({tag, "_err_x"}, err_x, 0);
      check({tag, "_err_y"}, err_y, 0);
      check({tag, "_err_data"}, err_data, 0);
`endif
   endtask

   task automatic do_reset_mid();
      rst = 1'b1;
      drive(0, 0, 0, 24'h0);
      rst = 1'b0;
      model_active = 1'b0;
      rep_q.delete();
      due_q.delete();
      check_all_zero("mid_reset");
   endtask

   task automatic send_pixel(input int x, input int y, input logic hs);
      logic [23:0] p, d;
      p = pattern(x, y);
      d = f_force_ff ? 24'hFFFFFF : p;
      if (x == f_err_x && y == f_err_y) d = d ^ 24'h1;
      if (f_rand_err && $urandom_range(0, 15) == 0) d = d ^ (24'h1 << $urandom_range(0, 23));
      if (d != p) begin
         if (acc.err == 16'd0) begin
            acc.ex = x[15:0];
            acc.ey = y[15:0];
            acc.ed = d;
         end
         if (acc.err != 16'hFFFF) acc.err = acc.err + 16'd1;
      end
      drive(1, hs, 0, d);
   endtask

   task automatic close_line(input int len);
      if (len > 0) begin
         acc.height = acc.height + 16'd1;
         if (!have_first) begin
            acc.width  = len[15:0];
            have_first = 1'b1;
         end else if (len[15:0] != acc.width) begin
            acc.mism = 1'b1;
         end
      end
   endtask

   // The first vsync cycle closes the previous frame; a report is expected one cycle later.
   task automatic send_vsync();
      rep_t r;
      for (int i = 0; i < f_vs_len; i++) begin
         if (i == 0 && model_active) begin
            r    = acc;
            r.ok = (acc.err == 16'd0) && !acc.mism;
            rep_q.push_back(r);
            due_q.push_back(cyc + 1);
         end
         drive(0, 0, 1, 24'h0);
      end
      acc          = '0;
      have_first   = 1'b0;
      model_active = 1'b1;
      drive(0, 0, 0, 24'h0);
   endtask

   task automatic send_body();
      bit prev_ov;
      int y;
      prev_ov = 1'b0;
      for (int b = 0; b < f_nb; b++) begin
         drive(0, 1, 0, 24'h0);
         drive(0, 0, 0, 24'h0);
      end
      for (int k = 0; k < f_lines; k++) begin
         y = f_nb + 1 + k;
         if (!prev_ov) drive(0, 1, 0, 24'h0);
         drive(0, 1, 0, 24'h0);
         drive(0, 0, 0, 24'h0);
         prev_ov = f_overlap && (k < f_lines - 1);
         for (int i = 0; i < f_len[k]; i++) begin
            if (k == f_rst_line && i == f_len[k] / 2) do_reset_mid();
            send_pixel(i, y, prev_ov && (i == f_len[k] - 1));
         end
         close_line(f_len[k]);
      end
      drive(0, 0, 0, 24'h0);
   endtask

   task automatic send_frame();
      send_vsync();
      send_body();
   endtask

   task automatic setup_800();
      f_nb = 2; f_lines = 3; f_vs_len = 2;
      for (int k = 0; k < 3; k++) f_len[k] = 800;
      f_overlap = 0; f_force_ff = 0; f_rand_err = 0;
      f_err_x = -1; f_err_y = -1; f_rst_line = -1;
   endtask

   task automatic setup_rand();
      int w;
      case ($urandom_range(0, 3))
         0: f_nb = 1;
         1: f_nb = 2;
         2: f_nb = 3;
         default: f_nb = 259;
      endcase
      f_lines  = int'($urandom_range(1, 4));
      f_vs_len = int'($urandom_range(1, 3));
      w        = int'($urandom_range(4, 40));
      f_len[0] = w;
      for (int k = 1; k < f_lines; k++)
         f_len[k] = ($urandom_range(0, 3) == 0) ? w + int'($urandom_range(0, 2)) - 1 : w;
      f_overlap  = ($urandom_range(0, 1) == 1);
      f_force_ff = 0; f_rand_err = 1;
      f_err_x = -1; f_err_y = -1; f_rst_line = -1;
   endtask

   // Every cycle: frame_done must match the scoreboard and outputs must hold the last report.
   initial begin : compare
      bit exp_done;
      cur = '0;
      forever begin
         @(negedge clk);
         if (rst !== 1'b0) begin
            cur = '0;
         end else begin
            exp_done = (due_q.size() > 0) && (due_q[0] == cyc);
            check("frame_done", frame_done, exp_done);
            if (exp_done) begin
               cur = rep_q.pop_front();
               void'(due_q.pop_front());
            end
            if (frame_done === 1'b1) done_seen++;
            check("frame_ok", frame_ok, cur.ok);
            check("err_count", err_count, cur.err);
            check("width", width, cur.width);
            check("height", height, cur.height);
            check("width_mismatch", width_mismatch, cur.mism);
`ifdef VIDEO_CHECK_FIRST_ERR_EN
            check("err_x", err_x, cur.ex);
            check("err_y", err_y, cur.ey);
            check("err_data", err_data, cur.ed);
`endif
         end
      end
   end

   initial begin : watchdog
      #1_500_000;
      $display("FAIL watchdog: bench did not finish in time");
      $fatal(1, "timeout");
   end

   initial begin : stim
      int done_before;
      acc = '0; have_first = 0; model_active = 0;
      rst = 1'b1; de = 0; hsync = 0; vsync = 0; data = 24'h0;
      repeat (3) drive(0, 0, 0, 24'h0);
      rst = 1'b0;
      drive(0, 0, 0, 24'h0);
      check_all_zero("reset");

      check("model_pattern_300_3", pattern(300, 3), 24'h2C0000);
      check("model_pattern_600_260", pattern(600, 260), 24'h000458);
      check("model_pattern_799_5", pattern(799, 5), 24'h1F001F);

      // Partial frame before any vsync: must be discarded
      setup_800(); f_nb = 0; f_lines = 1; f_len[0] = 50;
      send_body();

      setup_800(); send_frame();
      setup_800(); f_overlap = 1; send_frame();
      setup_800(); send_frame();
      check("clean_done_count", done_seen, 2);
      check("clean_locked", locked, 1);
      check("clean_frame_ok", frame_ok, 1);
      check("clean_err_count", err_count, 0);
      check("clean_width", width, 800);
      check("clean_height", height, 3);
      check("clean_mismatch", width_mismatch, 0);

      setup_800(); f_err_x = 300; f_err_y = 3; send_frame();
      setup_800(); f_len[1] = 799; send_frame();
      check("err_frame_err_count", err_count, 1);
      check("err_frame_ok", frame_ok, 0);
`ifdef VIDEO_CHECK_FIRST_ERR_EN
      check("err_frame_err_x", err_x, 300);
      check("err_frame_err_y", err_y, 3);
      check("err_frame_err_data", err_data, 24'h2C0001);
`endif

      setup_800(); f_lines = 70;
      for (int k = 0; k < 70; k++) f_len[k] = 1024;
      f_force_ff = 1;
      send_frame();
      check("short_line_mismatch", width_mismatch, 1);
      check("short_line_width", width, 800);
      check("short_line_height", height, 3);
      check("short_line_err_count", err_count, 0);
      check("short_line_ok", frame_ok, 0);

      setup_rand(); send_frame();
      check("sat_err_count", err_count, 16'hFFFF);
      check("sat_ok", frame_ok, 0);
      check("sat_width", width, 1024);
      check("sat_height", height, 70);

      // Reset in the middle of a frame, then the next report only after a full frame
      setup_rand(); f_rst_line = int'($urandom_range(0, f_lines - 1)); send_frame();
      done_before = done_seen;
      setup_rand(); send_frame();
      check("post_reset_no_report", done_seen, done_before);
      check("post_reset_locked", locked, 1);
      setup_rand(); send_frame();
      check("post_reset_first_report", done_seen, done_before + 1);

      for (int n = 0; n < 5; n++) begin
         setup_rand(); send_frame();
      end
      f_vs_len = 2;
      send_vsync();
      repeat (3) drive(0, 0, 0, 24'h0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
